// File: rtl/led_sequencer.sv
// LED bank sequencer: a shared prescaler drives a mode-selected pattern engine.
// Mode requests use valid/ready and only take effect on a tick boundary.
module led_sequencer #(
    parameter int TICK_DIV = 12_500_000,
    parameter int NUM_LED  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_mode_valid,
    input  logic [1:0]         i_mode,
    output logic               o_mode_ready,
    output logic [1:0]         o_mode,
    output logic [NUM_LED-1:0] o_led,
    output logic               o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    localparam logic [NUM_LED-1:0] LED_LO = {{(NUM_LED-1){1'b0}}, 1'b1};
    localparam logic [NUM_LED-1:0] LED_HI = {1'b1, {(NUM_LED-1){1'b0}}};

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_CHASE  = 2'd2;
    localparam logic [1:0] M_BOUNCE = 2'd3;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    state_t              state_q, state_d;
    dir_t                dir_q,   dir_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [1:0]          mode_q,  mode_d;
    logic [1:0]          pend_q,  pend_d;
    logic [NUM_LED-1:0]  led_q,   led_d;
    logic [NUM_LED-1:0]  shl,     shr;
    logic                tick;

    assign tick         = (cnt_q == LAST);
    assign o_tick       = tick;
    assign o_mode_ready = (state_q == RUN);
    assign o_mode       = mode_q;
    assign o_led        = led_q;

    assign shl = led_q << 1;
    assign shr = led_q >> 1;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        led_d   = led_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);

        if (state_q == PEND && tick) begin
            // Restart the pattern even when the requested mode is unchanged.
            mode_d  = pend_q;
            dir_d   = DIR_UP;
            state_d = RUN;
            unique case (pend_q)
                M_OFF:    led_d = '0;
                M_BLINK:  led_d = '1;
                M_CHASE:  led_d = LED_LO;
                M_BOUNCE: led_d = LED_LO;
                default:  led_d = '0;
            endcase
        end else begin
            if (tick) begin
                unique case (mode_q)
                    M_OFF:   led_d = '0;
                    M_BLINK: led_d = ~led_q;
                    M_CHASE: led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
                    M_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            led_d = shl;
                            if (shl == LED_HI) dir_d = DIR_DOWN;
                        end else begin
                            led_d = shr;
                            if (shr == LED_LO) dir_d = DIR_UP;
                        end
                    end
                    default: led_d = '0;
                endcase
            end
            // A request accepted on a tick edge waits for the following tick.
            if (state_q == RUN && i_mode_valid) begin
                pend_d  = i_mode;
                state_d = PEND;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            dir_q   <= DIR_UP;
            cnt_q   <= '0;
            mode_q  <= M_OFF;
            pend_q  <= M_OFF;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized scoreboard bench for led_sequencer with a tick-level
// reference model (pattern phase counters instead of shift registers).
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mv = 1'b0;
    logic [1:0] md = 2'd0;
    logic       o_mode_ready;
    logic [1:0] o_mode;
    logic [3:0] o_led;
    logic       o_tick;

    led_sequencer #(.TICK_DIV(4), .NUM_LED(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mode_valid (mv),
        .i_mode       (md),
        .o_mode_ready (o_mode_ready),
        .o_mode       (o_mode),
        .o_led        (o_led),
        .o_tick       (o_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic [1:0] mode;
        logic [3:0] led;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: edges since reset, mode, pattern phase, pending.
    int m_n = 0;
    int m_mode = 0;
    int m_phase = 0;
    int m_pend = -1;

    function automatic logic [3:0] pat(input int mode, input int ph);
        logic [3:0] bt [6];
        bt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
        case (mode)
            1:       return (ph % 2 == 0) ? 4'b1111 : 4'b0000;
            2:       return 4'(1 << (ph % 4));
            3:       return bt[ph % 6];
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [1:0] m);
        bit   had;
        exp_t e;
        @(negedge clk);
        rst_n = r;
        mv    = v;
        md    = m;
        @(posedge clk);
        if (!r) begin
            m_n = 0; m_mode = 0; m_phase = 0; m_pend = -1;
        end else begin
            had = (m_pend >= 0);
            m_n++;
            if (m_n % 4 == 0) begin
                if (had) begin
                    m_mode = m_pend; m_phase = 0; m_pend = -1;
                end else begin
                    m_phase++;
                end
            end
            if (v && !had) m_pend = int'(m);
        end
        e.rdy  = (m_pend < 0);
        e.mode = 2'(m_mode);
        e.led  = pat(m_mode, m_phase);
        e.tick = r && (m_n % 4 == 3);
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b1, 1'b0, 2'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({o_mode_ready, o_mode, o_led, o_tick} !== e) begin
                    n_bad++;
                    $display("FAIL cyc t=%0t got rdy=%b mode=%0d led=%b tick=%b exp rdy=%b mode=%0d led=%b tick=%b",
                             $time, o_mode_ready, o_mode, o_led, o_tick,
                             e.rdy, e.mode, e.led, e.tick);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog t=%0t got no finish exp finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, 2'd2);
        idle(24);
        cycle(1'b1, 1'b1, 2'd3);
        idle(36);
        cycle(1'b1, 1'b1, 2'd1);
        cycle(1'b1, 1'b1, 2'd3);
        cycle(1'b1, 1'b1, 2'd3);
        idle(14);
        while (m_n % 4 != 3) idle(1);
        cycle(1'b1, 1'b1, 2'd2);
        idle(12);
        cycle(1'b1, 1'b1, 2'd3);
        cycle(1'b0, 1'b0, 2'd0);
        idle(16);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0)
                cycle(1'b0, 1'b0, 2'd0);
            else
                cycle(1'b1, ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d left exp 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
